add_scheduler: RTL
==================

ADD_SCHEDULER -- requirements
Module: add_scheduler

Interface
REQ-001 Parameter: NIBBLES, 4, number of 4-bit passes per operation; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle when valid&&ready.
REQ-006 req0_a, req0_b  input  W each  requester 0 operands.
REQ-007 req0_cin  input  1  requester 0 carry-in.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_cin: same directions, widths and meanings for requester 1.
REQ-009 res_valid  output  1  result available.
REQ-010 res_ready  input  1  consumer takes result when res_valid&&res_ready.
REQ-011 res_sum  output  W+1  sum; MSB is final carry-out.
REQ-012 res_id  output  1  index of the requester that owns res_sum.

Function
REQ-013 The block shall time-share one 4-bit adder slice between both requesters, one nibble per cycle.
REQ-014 FSM states: IDLE, CALC, DONE; the state shall be IDLE out of reset.
REQ-015 IDLE: reqK_ready = 1 only for the granted requester, only when that requester is valid; the other ready = 0.
REQ-016 Grant: only one valid -> that one; both valid -> the requester indicated by the round-robin pointer.
REQ-017 After each accept, the pointer shall point to the requester not just granted; the pointer resets to 0.
REQ-018 On accept: capture a, b, cin and id into internal registers; go to CALC with nibble index 0; later changes on req inputs shall have no effect.
REQ-019 CALC cycle i (0..NIBBLES-1): slice adds a[4i+3:4i], b[4i+3:4i] and the carry register (cin at i=0); write sum nibble i; update carry register.
REQ-020 After nibble NIBBLES-1: res_sum[W] = final carry; go to DONE.
REQ-021 Latency: accept at edge t -> res_valid high after edge t+NIBBLES+1 (5 cycles for default).
REQ-022 DONE: res_valid = 1; res_sum and res_id held stable while res_ready = 0.
REQ-023 DONE and res_ready = 1 -> res_valid falls and state returns to IDLE on that edge; the earliest next accept is the following cycle.
REQ-024 Both reqK_ready shall be 0 in CALC and DONE.
REQ-025 res_sum and res_id shall keep their last values in IDLE and CALC and be valid only while res_valid = 1.
REQ-026 Arithmetic: unsigned, modulo-free; res_sum = a + b + cin exactly, W+1 bits.

Reset
REQ-027 rst_n low shall immediately force: state IDLE, res_valid 0, res_sum 0, res_id 0, carry 0, nibble index 0, pointer 0.
REQ-028 Both reqK_ready shall be 0 while rst_n is low.
REQ-029 Reset during CALC or DONE shall discard the in-flight operation and produce no result after release.

Structure
REQ-030 Package add_sched_pkg shall hold the FSM state enum, NIBBLES default and width constants.
REQ-031 Sub-module add4_slice shall be purely combinational: a[3:0], b[3:0], cin -> sum[3:0], cout.
REQ-032 add_scheduler shall instantiate exactly one add4_slice.

Verification
REQ-033 req0 only, a=0x1234, b=0x0FFF, cin=0 -> res_sum=0x02233, res_id=0, res_valid 5 cycles after accept.
REQ-034 a=0xFFFF, b=0x0000, cin=1 -> res_sum=0x10000 (carry ripples through all 4 nibbles).
REQ-035 a=0xFFFF, b=0xFFFF, cin=1 -> res_sum=0x1FFFF.
REQ-036 Both requesters continuously valid from reset, res_ready=1 -> grants alternate 0,1,0,1; res_id follows.
REQ-037 res_ready held 0 for 3 cycles in DONE -> res_valid, res_sum and res_id stable; both readies 0 until the handshake.
REQ-038 rst_n pulsed low in the 2nd CALC cycle -> res_valid 0 and no stale result after release; a new req1 op 0x0001+0x0001 -> 0x00002, id 1.

Source files
------------

// File: rtl/add_sched_pkg.sv
// add_sched_pkg: shared FSM encoding and width constants for add_scheduler.
// Rev 1.0
`default_nettype none

package add_sched_pkg;

  localparam int NIBBLES_DEF = 4;
  localparam int SLICE_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/add4_slice.sv
// add4_slice: combinational 4-bit adder slice with carry in/out.
// Rev 1.0
`default_nettype none

module add4_slice
  import add_sched_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_sum,
  output logic               o_cout
);

  logic [SLICE_W:0] w_total;

  assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{SLICE_W{1'b0}}, i_cin};
  assign o_sum   = w_total[SLICE_W-1:0];
  assign o_cout  = w_total[SLICE_W];

endmodule

`default_nettype wire

// File: rtl/add_scheduler.sv
// add_scheduler: two requesters share one 4-bit adder slice, one nibble per cycle.
// Rev 1.0
`default_nettype none

module add_scheduler
  import add_sched_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [4*NIBBLES-1:0]   req0_a,
  input  logic [4*NIBBLES-1:0]   req0_b,
  input  logic                   req0_cin,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [4*NIBBLES-1:0]   req1_a,
  input  logic [4*NIBBLES-1:0]   req1_b,
  input  logic                   req1_cin,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*NIBBLES:0]     res_sum,
  output logic                   res_id
);

  localparam int W     = SLICE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_work;
  logic               r_carry;
  logic               r_id;
  logic               r_ptr;
  logic [IDX_W-1:0]   r_idx;
  logic               r_res_valid;
  logic [W:0]         r_res_sum;
  logic               r_res_id;

  logic               w_grant1;
  logic               w_accept;
  logic               w_last;
  logic [SLICE_W-1:0] w_a_nib;
  logic [SLICE_W-1:0] w_b_nib;
  logic [SLICE_W-1:0] w_sum_nib;
  logic               w_cout;

  assign w_a_nib = r_a[{r_idx, 2'b00} +: SLICE_W];
  assign w_b_nib = r_b[{r_idx, 2'b00} +: SLICE_W];

  add4_slice u_slice (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_carry),
    .o_sum  (w_sum_nib),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Readies are gated by rst_n so nothing can be offered while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_grant1    = req1_valid && (!req0_valid || r_ptr);
    w_accept    = 1'b0;
    w_last      = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req0_ready = rst_n && req0_valid && !w_grant1;
        req1_ready = rst_n && w_grant1;
        w_accept   = req0_valid || req1_valid;
        if (w_accept) begin
          w_state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        w_last = (r_idx == c_LAST_IDX);
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (r_res_valid && res_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Nibbles accumulate in r_work so the published result stays untouched
  // until the whole sum is ready; DONE copies it out on its first cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_work      <= '0;
      r_carry     <= 1'b0;
      r_id        <= 1'b0;
      r_ptr       <= 1'b0;
      r_idx       <= '0;
      r_res_valid <= 1'b0;
      r_res_sum   <= '0;
      r_res_id    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a     <= w_grant1 ? req1_a   : req0_a;
            r_b     <= w_grant1 ? req1_b   : req0_b;
            r_carry <= w_grant1 ? req1_cin : req0_cin;
            r_id    <= w_grant1;
            r_ptr   <= !w_grant1;
            r_idx   <= '0;
          end
        end
        ST_CALC: begin
          r_work[{r_idx, 2'b00} +: SLICE_W] <= w_sum_nib;
          r_carry <= w_cout;
          r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
        end
        ST_DONE: begin
          if (!r_res_valid) begin
            r_res_valid <= 1'b1;
            r_res_sum   <= {r_carry, r_work};
            r_res_id    <= r_id;
          end else if (res_ready) begin
            r_res_valid <= 1'b0;
          end
        end
        default: begin
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_sum   = r_res_sum;
  assign res_id    = r_res_id;

endmodule

`default_nettype wire
